// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave
// Simple AHB-style SRAM slave with a programmable number of wait states,
// byte/halfword/word writes and a two-cycle error response for illegal
// accesses.
//
// Ports
//   clk        : single clock, all state changes on the rising edge
//   n_rst      : synchronous active-low reset
//   HADDR      : [31:28] slave select, [19:0] byte address
//   HWRITE     : 1 = write, 0 = read
//   HSIZE      : 00 byte, 01 halfword, 10 word, 11 illegal
//   HWDATA     : lane-aligned write data, held for the whole access
//   HRDATA     : registered read data (full word)
//   HREADY     : transfer complete / slave ready
//   HRESP      : 1 = error response
//   slv_error  : high for the single ERR2 cycle
//
// state  | meaning
// IDLE   | waiting for select; HREADY follows ~sel
// ACCESS | counting wait states down to zero
// DONE   | memory access performed, HREADY high
// ERR1   | first error cycle, HREADY low, HRESP high
// ERR2   | second error cycle, HREADY and HRESP high

module ahb_sram_slave #(
  parameter logic [3:0] BASE_NIBBLE = 4'b0101,
  parameter int         DEPTH_LOG2  = 8,
  parameter int         WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic        HRESP,
  output logic        slv_error
);

  typedef enum logic [2:0] {IDLE, ACCESS, DONE, ERR1, ERR2} state_t;

  localparam int         WS_LOAD  = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
  localparam logic [3:0] CNT_LOAD = 4'(WS_LOAD);
  localparam logic       HAS_WAIT = (WAIT_STATES > 0);

  state_t r_state;
  state_t w_next;
  logic [3:0]  r_cnt;
  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];

  logic                  w_sel;
  logic                  w_oor;
  logic                  w_illegal;
  logic [3:0]            w_be;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic                  w_unused_addr;

  assign w_sel         = (HADDR[31:28] == BASE_NIBBLE);
  assign w_idx         = HADDR[DEPTH_LOG2+1:2];
  assign w_unused_addr = &{1'b0, HADDR[27:20]};

  // Any address bit at or above the top word index makes the access out of range.
  assign w_oor = ((HADDR[19:0] >> (DEPTH_LOG2 + 2)) != 20'd0);

  always_comb begin
    w_be      = 4'b0000;
    w_illegal = w_oor;
    case (HSIZE)
      2'b00: w_be = 4'b0001 << HADDR[1:0];
      2'b01: begin
        w_be = HADDR[1] ? 4'b1100 : 4'b0011;
        if (HADDR[0]) w_illegal = 1'b1;
      end
      2'b10: begin
        w_be = 4'b1111;
        if (HADDR[1:0] != 2'b00) w_illegal = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next    = r_state;
    HREADY    = 1'b1;
    HRESP     = 1'b0;
    slv_error = 1'b0;
    w_wr_en   = 1'b0;
    w_rd_en   = 1'b0;
    case (r_state)
      IDLE: begin
        HREADY = ~w_sel;
        if (w_sel) begin
          if (w_illegal)     w_next = ERR1;
          else if (HAS_WAIT) w_next = ACCESS;
          else               w_next = DONE;
        end
      end
      ACCESS: begin
        HREADY = 1'b0;
        // Master abort: select dropped before completion.
        if (!w_sel)              w_next = IDLE;
        else if (r_cnt == 4'd0)  w_next = DONE;
      end
      DONE: begin
        w_next  = IDLE;
        w_wr_en = w_sel & HWRITE;
        w_rd_en = w_sel & ~HWRITE;
      end
      ERR1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
        w_next = ERR2;
      end
      ERR2: begin
        HRESP     = 1'b1;
        slv_error = 1'b1;
        w_next    = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      HRDATA  <= 32'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next == ACCESS)
        r_cnt <= CNT_LOAD;
      else if (r_state == ACCESS && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_rd_en)
        HRDATA <= r_mem[w_idx];
    end
  end

  // Storage is not reset; a write pending during reset is dropped.
  always_ff @(posedge clk) begin
    if (n_rst && w_wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter BASE_NIBBLE, default 4'b0101, select value compared against HADDR[31:28].
REQ-002 SHALL have parameter DEPTH_LOG2, default 8, giving 2^DEPTH_LOG2 32-bit words of internal storage.
REQ-003 SHALL have parameter WAIT_STATES, default 1, range 0..15, giving extra wait cycles per access.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 n_rst  input  1  reset, synchronous, active-low.
REQ-006 HADDR  input  32  address from master; [31:28] select, [19:0] byte address.
REQ-007 HWRITE  input  1  1 = write, 0 = read.
REQ-008 HSIZE  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 HWDATA  input  32  write data, lane-aligned, held by master for the whole access.
REQ-010 HRDATA  output  32  registered read data.
REQ-011 HREADY  output  1  transfer-complete / slave-ready.
REQ-012 HRESP  output  1  1 = error response.
REQ-013 slv_error  output  1  one-cycle pulse in ERR2.

Function
REQ-014 sel SHALL be (HADDR[31:28] == BASE_NIBBLE); all other inputs SHALL be ignored while sel = 0.
REQ-015 An access SHALL be illegal if HSIZE = 11, if halfword and HADDR[0] = 1, if word and HADDR[1:0] != 0, or if HADDR[19:DEPTH_LOG2+2] != 0 (out of range).
REQ-016 FSM states SHALL be IDLE, ACCESS, DONE, ERR1 and ERR2.
REQ-017 IDLE: HREADY = ~sel (combinational) and HRESP = 0; if sel is legal, go to ACCESS when WAIT_STATES > 0, else to DONE; if sel is illegal, go to ERR1; with no sel, stay in IDLE.
REQ-018 On entry to ACCESS, a 4-bit counter SHALL load WAIT_STATES-1.
REQ-019 ACCESS: HREADY = 0, HRESP = 0; at count 0 go to DONE, else decrement.
REQ-020 ACCESS: if sel drops (master abort), return to IDLE with no memory write and HRDATA unchanged.
REQ-021 DONE: HREADY = 1, HRESP = 0; the access SHALL be performed using HADDR, HWRITE, HSIZE and HWDATA as sampled in this cycle; next state IDLE.
REQ-022 Read in DONE: HRDATA SHALL load the full word at index HADDR[DEPTH_LOG2+1:2], regardless of HSIZE, and hold until the next completed read.
REQ-023 Write in DONE, byte access: only the byte lane at HADDR[1:0] SHALL update, taken from the same HWDATA lane.
REQ-024 Write in DONE, halfword access: only the lanes selected by HADDR[1] SHALL update.
REQ-025 Write in DONE, word access: all four lanes SHALL update.
REQ-026 Latency: HREADY SHALL be low for exactly 1+WAIT_STATES cycles after sel rises, then high for one DONE cycle.
REQ-027 ERR1: HREADY = 0, HRESP = 1; next state ERR2.
REQ-028 ERR2: HREADY = 1, HRESP = 1, slv_error = 1; next state IDLE.
REQ-029 An illegal access SHALL never modify memory or HRDATA.
REQ-030 Back-to-back: sel high in the cycle after DONE or ERR2 SHALL start a new access from IDLE.

Reset
REQ-031 When n_rst = 0 at a clock edge: state IDLE, counter 0, HRDATA 0, slv_error 0.
REQ-032 After reset, HREADY SHALL be 1 and HRESP 0 while sel = 0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 Reset asserted during ACCESS or DONE SHALL suppress any pending write.

Verification
REQ-035 Word write then read: write HADDR 0x5000_0010, HSIZE 10, HWDATA 0xDEADBEEF; then read the same address -> HREADY low exactly 2 cycles each (WAIT_STATES = 1), and HRDATA = 0xDEADBEEF after the read DONE.
REQ-036 Byte write: after REQ-035, write byte at 0x5000_0012 with HWDATA 0x00AA_0000, then read the word -> HRDATA = 0xDEAABEEF.
REQ-037 Misaligned word read at 0x5000_0011 -> one cycle HREADY = 0/HRESP = 0, then ERR1 (0/1), then ERR2 (1/1) with slv_error pulse; HRDATA unchanged.
REQ-038 Out-of-range word write at 0x5000_0400 (DEPTH_LOG2 = 8) -> error sequence as in REQ-037; a later read of index 0 returns its previous value.
REQ-039 Abort: sel dropped in ACCESS with WAIT_STATES = 3 during a write of 0x12345678 -> FSM returns to IDLE, HREADY = 1, memory unchanged.
REQ-040 Reset mid-access: n_rst = 0 during DONE of a write -> memory unchanged, HRDATA = 0, HREADY = 1 next cycle.
